// File: rtl/mem_block_reader_pkg.sv
// rtl/mem_block_reader_pkg.sv - shared types and default widths for the block reader
package mem_block_reader_pkg;

  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_LEN_W        = 16;
  localparam int DEF_READ_LATENCY = 1;
  localparam int DEF_FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic                  last;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/mem_block_reader_fifo.sv
// rtl/mem_block_reader_fifo.sv - synchronous output buffer with occupancy count
module mem_block_reader_fifo
  import mem_block_reader_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Push and pop may coincide when full; the caller's credit rule prevents overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/mem_block_reader.sv
// rtl/mem_block_reader.sv - Avalon-MM block read master feeding a buffered valid/ready stream
module mem_block_reader
  import mem_block_reader_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  output logic                st_valid,
  input  logic                st_ready,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_last,
  output logic                busy,
  output logic                done
);

  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 2;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic                    rd_q, rd_d;
  logic                    done_q, done_d;
  logic [READ_LATENCY-1:0] pv_q, pv_d, pl_q, pl_d;
  logic [FC_W-1:0]         fifo_count;
  logic [DATA_W:0]         fifo_rdata;
  logic                    fifo_empty, accept, pop;
  logic [CNT_W-1:0]        outstanding, credit;

  assign accept       = rd_q & ~m_waitrequest;
  assign st_valid     = ~fifo_empty;
  assign pop          = st_valid & st_ready;
  assign st_data      = fifo_rdata[DATA_W-1:0];
  assign st_last      = st_valid & fifo_rdata[DATA_W];
  assign m_address    = addr_q;
  assign m_read       = rd_q;
  assign m_chipselect = rd_q;
  assign m_write      = 1'b0;
  assign m_byteenable = '1;
  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    pv_d    = READ_LATENCY'({pv_q, accept});
    pl_d    = READ_LATENCY'({pl_q, accept & (rem_q == LEN_W'(1))});

    outstanding = '0;
    for (int i = 0; i < READ_LATENCY; i++) outstanding = outstanding + CNT_W'(pv_q[i]);
    // The read being accepted now still needs a FIFO slot, so it counts against credit.
    credit = outstanding + CNT_W'(fifo_count) + CNT_W'(accept);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            rd_d    = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
        end
        if (accept && rem_q == LEN_W'(1)) begin
          rd_d    = 1'b0;
          state_d = DRAIN;
        end else if (!(rd_q && m_waitrequest)) begin
          rd_d = (credit < CNT_W'(FIFO_DEPTH));
        end
      end
      DRAIN: begin
        if (outstanding == '0 && fifo_count == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      pv_q    <= '0;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
    end
  end

  mem_block_reader_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset_n(reset_n),
    .push  (pv_q[READ_LATENCY-1]),
    .wdata ({pl_q[READ_LATENCY-1], m_readdata}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mem_block_reader.sv
// tb/tb_mem_block_reader.sv - randomized scoreboard bench for the block reader
module tb_mem_block_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic [15:0] m_address;
  logic        m_chipselect, m_read, m_write;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = '0;
  logic        st_valid;
  logic        st_ready = 1'b1;
  logic [31:0] st_data;
  logic        st_last, busy, done;

  always #5 clk = ~clk;

  mem_block_reader dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .m_address(m_address),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data), .st_last(st_last),
    .busy(busy), .done(done)
  );

  // On-chip memory slave with one cycle of read latency.
  logic [31:0] mem [65536];
  always @(posedge clk) if (m_read && !m_waitrequest) m_readdata <= mem[m_address];

  int n_cmp = 0, n_bad = 0;
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the words a command must produce, in order, and the addresses it must read.
  logic [31:0] q_data[$];
  logic        q_last[$];
  logic [15:0] q_addr[$];

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int t_acc, t_first, t_lastpop, t_done, cur_len;
  int n_done, n_rd, n_busy, n_acc, n_pop, n_gap, max_infl, wr_hold;
  bit first_seen, rdy_at_done;
  int rdy_mode = 0, wt_mode = 0;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: st_ready = 1'b1;
      1: st_ready = ($urandom_range(0, 2) != 0);
      default: st_ready = (cyc_n - t_acc > 10) ? ~st_ready : 1'b0;
    endcase
    case (wt_mode)
      0: m_waitrequest = 1'b0;
      1: m_waitrequest = m_read && ($urandom_range(0, 3) == 0);
      default: begin
        m_waitrequest = m_read && (n_acc == 1) && (wr_hold < 3);
        if (m_waitrequest) wr_hold++;
      end
    endcase
  end

  logic        p_hold, p_stall, p_last;
  logic [15:0] p_addr;
  logic [31:0] p_data;
  logic [63:0] ea, ed, el;
  always @(negedge clk) begin
    if (!reset_n) begin
      q_data.delete(); q_last.delete(); q_addr.delete();
      p_hold = 1'b0; p_stall = 1'b0; n_acc = 0; n_pop = 0;
    end else begin
      if (p_hold) begin
        check_eq("hold_read", m_read, 1);
        check_eq("hold_addr", m_address, p_addr);
      end
      if (p_stall) begin
        check_eq("stall_valid", st_valid, 1);
        check_eq("stall_data", st_data, p_data);
        check_eq("stall_last", st_last, p_last);
      end
      if (m_read) n_rd++;
      if (busy) n_busy++;
      if (busy && !m_read && n_acc < cur_len) n_gap++;
      if (m_read && !m_waitrequest) begin
        ea = 64'hDEAD_DEAD_DEAD_DEAD;
        if (q_addr.size() != 0) ea = 64'(q_addr.pop_front());
        check_eq("read_addr", m_address, ea);
        n_acc++;
      end
      if (st_valid && !first_seen) begin first_seen = 1'b1; t_first = cyc_n; end
      if (st_valid && st_ready) begin
        ed = 64'hDEAD_DEAD_DEAD_DEAD;
        el = 64'hDEAD_DEAD_DEAD_DEAD;
        if (q_data.size() != 0) begin
          ed = 64'(q_data.pop_front());
          el = 64'(q_last.pop_front());
        end
        check_eq("st_data", st_data, ed);
        check_eq("st_last", st_last, el);
        n_pop++;
        t_lastpop = cyc_n;
      end
      if (n_acc - n_pop > max_infl) max_infl = n_acc - n_pop;
      if (done) begin n_done++; t_done = cyc_n; rdy_at_done = cmd_ready; end
      p_hold = m_read && m_waitrequest; p_addr = m_address;
      p_stall = st_valid && !st_ready; p_data = st_data; p_last = st_last;
    end
  end

  task automatic start_cmd(input logic [15:0] a, input logic [15:0] len, input int rm, input int wm);
    int k;
    rdy_mode = rm; wt_mode = wm;
    k = 0;
    while (!cmd_ready && k < 100) begin @(posedge clk); #1; k++; end
    check_eq("cmd_ready_wait", cmd_ready, 1);
    for (int i = 0; i < int'(len); i++) begin
      q_addr.push_back(16'(int'(a) + i));
      q_data.push_back(mem[16'(int'(a) + i)]);
      q_last.push_back(i == int'(len) - 1);
    end
    n_done = 0; n_rd = 0; n_busy = 0; n_acc = 0; n_pop = 0; n_gap = 0;
    max_infl = 0; wr_hold = 0; first_seen = 1'b0; cur_len = int'(len);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = len; t_acc = cyc_n;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input logic [15:0] len);
    int k;
    k = 0;
    while (n_done == 0 && k < 3000) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    check_eq("done_pulses", n_done, 1);
    check_eq("ready_at_done", rdy_at_done, 1);
    check_eq("words_popped", n_pop, len);
    check_eq("queue_empty", q_data.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = $urandom();
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + 32'(i);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check_eq("rst_m_read", m_read, 0);
    check_eq("rst_chipselect", m_chipselect, 0);
    check_eq("rst_st_valid", st_valid, 0);
    check_eq("rst_st_last", st_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("tie_write", m_write, 0);
    check_eq("tie_byteenable", m_byteenable, 4'hF);

    start_cmd(16'h0010, 16'd4, 0, 0);
    finish_cmd(16'd4);
    check_eq("basic_first_latency", t_first - t_acc, 3);
    check_eq("basic_back_to_back", t_lastpop - t_first, 3);

    start_cmd(16'h1234, 16'd0, 0, 0);
    finish_cmd(16'd0);
    check_eq("zero_no_read", n_rd, 0);
    check_eq("zero_no_busy", n_busy, 0);
    check_eq("zero_done_time", t_done - t_acc, 1);

    start_cmd(16'hFFFE, 16'd4, 0, 0);
    finish_cmd(16'd4);
    check_eq("wrap_reads", n_acc, 4);

    start_cmd(16'h0400, 16'd16, 2, 0);
    finish_cmd(16'd16);
    check_eq("bp_credit_le_depth", max_infl <= 4, 1);
    check_eq("bp_read_throttled", n_gap > 0, 1);

    start_cmd(16'h0800, 16'd16, 0, 2);
    finish_cmd(16'd16);
    check_eq("wait_cycles_seen", wr_hold, 3);

    start_cmd(16'h0200, 16'd16, 0, 0);
    for (int k = 0; k < 200 && n_pop < 5; k++) begin @(posedge clk); #1; end
    check_eq("reset_reached_5", n_pop >= 5, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_eq("abort_st_valid", st_valid, 0);
    check_eq("abort_m_read", m_read, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_cmd_ready", cmd_ready, 1);
    start_cmd(16'h0300, 16'd2, 0, 0);
    finish_cmd(16'd2);

    for (int r = 0; r < 10; r++) begin
      logic [15:0] a, l;
      a = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom());
      l = 16'($urandom_range(1, 24));
      start_cmd(a, l, $urandom_range(0, 1), $urandom_range(0, 1));
      finish_cmd(l);
      check_eq("rand_credit_le_depth", max_infl <= 4, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
